img2col_pixel_fetch: RTL

Responder side of the img2col mapping interface. Accepts (round, row, PU, tap-column) index requests from the mapping controller and converts each into a linear image-memory address. Issues the read and returns the pixel, tagged with its destination PU and tap, through a 4-entry output FIFO to the processing-unit array. Sits between the mapping controller and the image SRAM read port; also owns frame start/finish sequencing.

---
 rtl/img2col_pixel_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/img2col_pixel_fetch.sv
// img2col responder: turns (round, row, PU, tap-column) requests into image-SRAM reads and returns
// PU/tap-tagged pixels through a 4-entry FIFO. Optional range checking: IMG2COL_FETCH_BOUNDS_EN.
module img2col_pixel_fetch #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int K     = 5,
   parameter int NPU   = 28,
   parameter int DW    = 8,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [5:0]    req_round,
   input  logic [5:0]    req_row,
   input  logic [5:0]    req_pu,
   input  logic [5:0]    req_col,
   input  logic          req_last,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [DW-1:0] pix_data,
   output logic [5:0]    pix_pu,
   output logic [5:0]    pix_tap,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

`ifdef IMG2COL_FETCH_BOUNDS_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   state_t          state_r, state_nxt_s;
   logic            ready_s, done_nxt_s, drained_s, acc_s, oob_s;
   logic [AW-1:0]   addr_s;
   logic [5:0]      tap_s;
   logic [1:0]      inflight_s;
   logic            s1_valid_r, s1_oob_r, s2_valid_r, s2_oob_r;
   logic [5:0]      s1_pu_r, s1_tap_r, s2_pu_r, s2_tap_r;
   logic [2:0]      count_r;
   logic [1:0]      wr_ptr_r, rd_ptr_r;
   logic            push_s, pop_s;
   logic            mem_en_r, done_r, err_r;
   logic [AW-1:0]   mem_addr_r;
   logic [DW-1:0]   fifo_data_r [4];
   logic [5:0]      fifo_pu_r [4];
   logic [5:0]      fifo_tap_r [4];

   // Address is modular in AW bits, identical to computing wide and truncating.
   assign addr_s = AW'((32'(req_round) + 32'(req_row)) * 32'(IMG_W) + 32'(req_pu) + 32'(req_col));
   assign tap_s  = 6'(32'(req_row) * 32'(K) + 32'(req_col));
   assign oob_s  = BOUNDS_EN && ((32'(req_row) >= 32'(K)) || (32'(req_col) >= 32'(K)) ||
                                 (32'(req_pu) >= 32'(NPU)) || (32'(req_round) > 32'(IMG_H - K)));

   assign inflight_s = {1'b0, s1_valid_r} + {1'b0, s2_valid_r};
   assign drained_s  = (inflight_s == 2'd0) && (count_r == 3'd0);
   assign acc_s      = req_valid && ready_s;
   assign push_s     = s2_valid_r;
   assign pop_s      = pix_valid && pix_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (start) state_nxt_s = RUN; else state_nxt_s = IDLE;
         RUN:     if (acc_s && req_last) state_nxt_s = DRAIN; else state_nxt_s = RUN;
         DRAIN:   if (drained_s) state_nxt_s = IDLE; else state_nxt_s = DRAIN;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: request handshake and frame-complete strobe
   always_comb begin
      ready_s    = 1'b0;
      done_nxt_s = 1'b0;
      case (state_r)
         RUN:     ready_s = (({1'b0, count_r} + {2'b00, inflight_s}) < 4'd4);
         DRAIN:   done_nxt_s = drained_s;
         default: ready_s = 1'b0;
      endcase
   end

   // Read-issue and tag pipeline, done strobe and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en_r   <= 1'b0;
         mem_addr_r <= '0;
         s1_valid_r <= 1'b0;
         s1_oob_r   <= 1'b0;
         s1_pu_r    <= 6'd0;
         s1_tap_r   <= 6'd0;
         s2_valid_r <= 1'b0;
         s2_oob_r   <= 1'b0;
         s2_pu_r    <= 6'd0;
         s2_tap_r   <= 6'd0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         mem_en_r   <= acc_s && !oob_s;
         s1_valid_r <= acc_s;
         if (acc_s) begin
            mem_addr_r <= addr_s;
            s1_oob_r   <= oob_s;
            s1_pu_r    <= req_pu;
            s1_tap_r   <= tap_s;
         end
         s2_valid_r <= s1_valid_r;
         s2_oob_r   <= s1_oob_r;
         s2_pu_r    <= s1_pu_r;
         s2_tap_r   <= s1_tap_r;
         done_r     <= done_nxt_s;
         if (state_r == IDLE && start) err_r <= 1'b0;
         else if (acc_s && oob_s)      err_r <= 1'b1;
      end
   end

   // Output FIFO; occupancy accounting in RUN guarantees a free slot for every push
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= 2'd0;
         rd_ptr_r <= 2'd0;
         count_r  <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            fifo_data_r[i] <= '0;
            fifo_pu_r[i]   <= 6'd0;
            fifo_tap_r[i]  <= 6'd0;
         end
      end else begin
         if (push_s) begin
            fifo_data_r[wr_ptr_r] <= s2_oob_r ? '0 : mem_rdata;
            fifo_pu_r[wr_ptr_r]   <= s2_pu_r;
            fifo_tap_r[wr_ptr_r]  <= s2_tap_r;
            wr_ptr_r              <= wr_ptr_r + 2'd1;
         end
         if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign req_ready = ready_s;
   assign mem_en    = mem_en_r;
   assign mem_addr  = mem_addr_r;
   assign pix_valid = (count_r != 3'd0);
   assign pix_data  = fifo_data_r[rd_ptr_r];
   assign pix_pu    = fifo_pu_r[rd_ptr_r];
   assign pix_tap   = fifo_tap_r[rd_ptr_r];
   assign done      = done_r;
   assign err       = err_r;

endmodule
